// File: rtl/mux_arb_n_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
// Purpose : Shared definitions for the mux_arb_n block and its bench.
//           - mode_e       : selection mode encoding (fixed select / round-robin)
//           - MAX_NCH      : largest supported channel count (bench sizing)
//           - sel_in_range : true when a select value names an existing channel
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned MAX_NCH = 16;

  // Select values at or above the channel count (non power-of-two NCH) never grant.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned nch);
    return (sel < nch);
  endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// ---------------------------------------------------------------------------
// mux_arb_n_if
// Purpose : Bundles the producer-side and consumer-side handshake signals of
//           mux_arb_n.
//   in_data  [NCH*W] channel i in bits [i*W +: W]
//   in_valid [NCH]   channel i offers a word
//   in_ready [NCH]   one-hot/zero grant back to the producers
//   S        [SW]    fixed-mode channel select
//   mode     [1]     0 fixed select, 1 round-robin
//   out_data [W]     registered selected word
//   out_valid        out_data holds an unconsumed word
//   out_ready        consumer accepts out_data
//   out_ch   [SW]    channel that produced out_data
// Modports: slave  = the multiplexer itself
//           master = the environment driving producers/consumer
// ---------------------------------------------------------------------------
interface mux_arb_n_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int SW = $clog2(NCH);

  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic [SW-1:0]    S;
  logic             mode;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_ch;

  modport slave (
    input  in_data, in_valid, S, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );

  modport master (
    output in_data, in_valid, S, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purpose : Combinational round-robin picker. Scans req starting at ptr+1,
//           wrapping modulo NCH, and returns the first requesting index.
//   req   [NCH] request vector
//   ptr   [SW]  index granted last; it has the lowest priority this time
//   found       at least one request is set
//   idx   [SW]  chosen index (0 when found=0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NCH = 4,
  localparam int SW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic           found,
  output logic [SW-1:0]  idx
);

  logic [SW-1:0] pos_s;

  // Scan from the farthest offset down to ptr+1 so the nearest request wins.
  always_comb begin
    found = 1'b0;
    idx   = {SW{1'b0}};
    pos_s = {SW{1'b0}};
    for (int k = NCH; k >= 1; k--) begin
      pos_s = SW'((int'(ptr) + k) % NCH);
      if (req[pos_s]) begin
        found = 1'b1;
        idx   = pos_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// ---------------------------------------------------------------------------
// mux_arb_n
// Purpose : Registered NCH-channel, W-bit multiplexer with per-channel
//           valid/ready. One channel is granted per transfer, either by the
//           explicit select S (mode=0) or round-robin among valid channels
//           (mode=1). The chosen word lands in a single output register that
//           is drained by out_valid/out_ready at up to one word per cycle.
// Ports   : clk    rising-edge clock
//           reset  synchronous, active-high
//           bus    mux_arb_n_if.slave (see interface header)
// ---------------------------------------------------------------------------
module mux_arb_n
  import mux_arb_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int W   = 8,
  localparam int SW  = $clog2(NCH)
) (
  input logic         clk,
  input logic         reset,
  mux_arb_n_if.slave  bus
);

  // Output register and round-robin pointer.
  logic [W-1:0]  out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [W-1:0]  word_s [NCH];
  logic          ld_s;
  logic          fixed_found_s;
  logic [SW-1:0] fixed_idx_s;
  logic          rr_found_s;
  logic [SW-1:0] rr_idx_s;
  logic          cand_found_s;
  logic [SW-1:0] cand_idx_s;
  logic          grant_s;
  logic [NCH-1:0] in_ready_s;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .req   (bus.in_valid),
    .ptr   (ptr_q),
    .found (rr_found_s),
    .idx   (rr_idx_s)
  );

  // Split the flat input bus into per-channel words.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      word_s[i] = bus.in_data[i*W +: W];
    end
  end

  // Fixed-mode candidate: only an in-range, valid select qualifies.
  always_comb begin
    fixed_found_s = 1'b0;
    fixed_idx_s   = bus.S;
    if (sel_in_range(int'(bus.S), NCH)) begin
      fixed_found_s = bus.in_valid[bus.S];
    end else begin
      fixed_found_s = 1'b0;
    end
  end

  // Mode mux between the fixed select and the round-robin pick.
  always_comb begin
    cand_found_s = 1'b0;
    cand_idx_s   = {SW{1'b0}};
    case (bus.mode)
      MODE_FIXED: begin
        cand_found_s = fixed_found_s;
        cand_idx_s   = fixed_idx_s;
      end
      MODE_RR: begin
        cand_found_s = rr_found_s;
        cand_idx_s   = rr_idx_s;
      end
      default: begin
        cand_found_s = 1'b0;
        cand_idx_s   = {SW{1'b0}};
      end
    endcase
  end

  // Grant: the register can load when empty or being drained this cycle.
  // The candidate is already known valid, so a grant is always a transfer.
  always_comb begin
    ld_s       = !out_valid_q || bus.out_ready;
    grant_s    = ld_s && cand_found_s && !reset;
    in_ready_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      in_ready_s[i] = grant_s && (cand_idx_s == SW'(i));
    end
  end

  // Next state: load on grant, otherwise drain or hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (grant_s) begin
      out_data_d  = word_s[cand_idx_s];
      out_ch_d    = cand_idx_s;
      out_valid_d = 1'b1;
      if (bus.mode == MODE_RR) begin
        ptr_d = cand_idx_s;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; ptr resets to NCH-1 so channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= {W{1'b0}};
      out_valid_q <= 1'b0;
      out_ch_q    <= {SW{1'b0}};
      ptr_q       <= SW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_n
// Purpose : Directed bench for mux_arb_n (NCH=4, W=8). The stimulus process
//           checks grants each cycle and queues the word each grant should
//           deliver; a monitor pops and compares whenever the output is
//           consumed.
// ---------------------------------------------------------------------------
module tb_mux_arb_n;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ch_data [4];
  exp_t       q [$];
  exp_t       mon_e;
  int         total = 0;
  int         bad   = 0;

  mux_arb_n_if #(.NCH(4), .W(8)) bus ();

  mux_arb_n #(.NCH(4), .W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_comb bus.in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  // Monitor: every consumed output word must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: got data=%h ch=%0d, required no output", bus.out_data, bus.out_ch);
      end else begin
        mon_e = q.pop_front();
        if (bus.out_data !== mon_e.d || bus.out_ch !== mon_e.ch) begin
          bad++;
          $display("FAIL mon_word: got data=%h ch=%0d, required data=%h ch=%0d",
                   bus.out_data, bus.out_ch, mon_e.d, mon_e.ch);
        end
      end
    end
  end

  // One cycle: check grant and out_valid before the edge, queue the expected word.
  task automatic tick(input logic [3:0] exp_rdy, input logic exp_ov, input string nm);
    #3;
    total++;
    if (bus.in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL %s in_ready: got %b, required %b", nm, bus.in_ready, exp_rdy);
    end
    total++;
    if (bus.out_valid !== exp_ov) begin
      bad++;
      $display("FAIL %s out_valid: got %b, required %b", nm, bus.out_valid, exp_ov);
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) q.push_back('{d: ch_data[i], ch: 2'(i)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input logic [7:0] d, input logic [1:0] ch, input string nm);
    total++;
    if (bus.out_data !== d || bus.out_ch !== ch) begin
      bad++;
      $display("FAIL %s: got data=%h ch=%0d, required data=%h ch=%0d", nm, bus.out_data, bus.out_ch, d, ch);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_data[0] = 8'h11; ch_data[1] = 8'h22; ch_data[2] = 8'h33; ch_data[3] = 8'h44;
    reset         = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.mode      = 1'b1;
    bus.S         = 2'd0;
    bus.out_ready = 1'b1;

    // Reset held 2 cycles with every channel valid.
    @(posedge clk);
    #1;
    tick(4'b0000, 1'b0, "rst");
    check_out(8'h00, 2'd0, "rst_out");
    reset = 1'b0;

    // RR all-valid: 0,1,2,3,0,1,2,3 with no bubbles.
    tick(4'b0001, 1'b0, "rr_first");
    tick(4'b0010, 1'b1, "rr_1");
    tick(4'b0100, 1'b1, "rr_2");
    tick(4'b1000, 1'b1, "rr_3");
    tick(4'b0001, 1'b1, "rr_4");
    tick(4'b0010, 1'b1, "rr_5");
    tick(4'b0100, 1'b1, "rr_6");
    tick(4'b1000, 1'b1, "rr_7");

    // Fixed mode, S=2.
    bus.mode   = 1'b0;
    bus.S      = 2'd2;
    ch_data[2] = 8'hA5;
    tick(4'b0100, 1'b1, "fix_s2");
    check_out(8'hA5, 2'd2, "fix_out");
    bus.in_valid = 4'b0000;
    tick(4'b0000, 1'b1, "fix_drain");
    tick(4'b0000, 1'b0, "fix_idle");
    check_out(8'hA5, 2'd2, "drain_hold");

    // RR sparse after reset: 1,3,1,3.
    reset = 1'b1;
    tick(4'b0000, 1'b0, "sp_rst");
    reset        = 1'b0;
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1010;
    tick(4'b0010, 1'b0, "sp_1");
    tick(4'b1000, 1'b1, "sp_3");
    tick(4'b0010, 1'b1, "sp_1b");
    tick(4'b1000, 1'b1, "sp_3b");
    bus.in_valid = 4'b0000;
    tick(4'b0000, 1'b1, "sp_drain");
    tick(4'b0000, 1'b0, "sp_idle");

    // Back-pressure: output frozen, then drain and reload in the same cycle.
    bus.in_valid = 4'b1111;
    tick(4'b0001, 1'b0, "bp_load");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(4'b0000, 1'b1, "bp_hold");
      check_out(8'h11, 2'd0, "bp_stable");
    end
    bus.out_ready = 1'b1;
    tick(4'b0010, 1'b1, "bp_release");
    check_out(8'h22, 2'd1, "bp_next");
    bus.in_valid = 4'b0000;
    tick(4'b0000, 1'b1, "bp_drain");
    tick(4'b0000, 1'b0, "bp_idle");

    // Reset mid-operation with ptr=2: first grant afterwards is ch0.
    bus.in_valid = 4'b1111;
    tick(4'b0100, 1'b0, "mr_load2");
    reset = 1'b1;
    tick(4'b0000, 1'b1, "mr_rst");
    reset = 1'b0;
    tick(4'b0001, 1'b0, "mr_first");
    bus.in_valid = 4'b0000;
    tick(4'b0000, 1'b1, "mr_drain");
    tick(4'b0000, 1'b0, "mr_idle");

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_empty: got %0d pending words, required 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
